// File: rtl/wb_burst_checker_pkg.sv
// Shared constants, state type and CTI helper for the Wishbone burst checker.
package wb_checker_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INC     = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        WR_BURST,
        WR_GAP,
        RD_BURST,
        RD_GAP,
        DONE
    } chk_state_t;

    // A last-beat index of zero means single-beat bursts, which use classic cycles.
    function automatic logic [2:0] beat_cti(input logic [3:0] beat, input logic [3:0] last_beat);
        if (last_beat == 4'd0)
            return CTI_CLASSIC;
        else if (beat == last_beat)
            return CTI_EOB;
        else
            return CTI_INC;
    endfunction

endpackage

// File: rtl/wb_burst_checker_if.sv
// Wishbone B3 master-side bus bundle between the burst checker and one SDRAM slave port.
interface wb_burst_checker_if;

    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic [2:0]  wbm_cti_o;
    logic [1:0]  wbm_bte_o;
    logic        wbm_we_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;

    modport master (
        output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_cti_o, wbm_bte_o,
               wbm_we_o, wbm_cyc_o, wbm_stb_o,
        input  wbm_dat_i, wbm_ack_i
    );

    modport slave (
        input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_cti_o, wbm_bte_o,
               wbm_we_o, wbm_cyc_o, wbm_stb_o,
        output wbm_dat_i, wbm_ack_i
    );

endinterface

// File: rtl/wb_burst_checker_pattern.sv
// Address-derived test pattern, used both to generate write data and to check read data.
module wb_checker_pattern #(
    parameter logic [31:0] SEED = 32'hA5A5_0000
) (
    input  logic [31:0] adr,
    output logic [31:0] pattern
);

    assign pattern = {adr[31:2], 2'b00} ^ SEED;

endmodule

// File: rtl/wb_burst_checker.sv
// Wishbone burst master that writes a pattern, reads it back and reports mismatches and ack timeouts.
module wb_burst_checker
    import wb_checker_pkg::*;
#(
    parameter logic [31:0] BASE_ADR  = 32'h0000_0000,
    parameter int          BURST_LEN = 4,
    parameter int          NR_BURSTS = 16,
    parameter logic [31:0] SEED      = 32'hA5A5_0000,
    parameter int          TIMEOUT   = 1023
) (
    input  logic                wb_clk,
    input  logic                wb_rst,
    input  logic                start,
    wb_burst_checker_if.master  wbm,
    output logic                busy,
    output logic                done,
    output logic                ok,
    output logic                timeout,
    output logic [15:0]         err_count,
    output logic [31:0]         first_err_adr
);

    localparam logic [31:0] BASE      = {BASE_ADR[31:2], 2'b00};
    localparam logic [3:0]  LAST_BEAT = 4'(BURST_LEN - 1);
    localparam logic [15:0] BURSTS    = 16'(NR_BURSTS);
    localparam logic [31:0] TMO       = 32'(TIMEOUT);

    chk_state_t  state, state_nxt;
    logic [3:0]  beat_cnt, beat_nxt;
    logic [15:0] burst_cnt, burst_nxt;
    logic [31:0] wait_cnt, wait_nxt;
    logic [31:0] adr_nxt, dat_nxt, pat_nxt;
    logic [2:0]  cti_nxt;
    logic        we_nxt, cyc_nxt, stb_nxt;
    logic        busy_nxt, done_nxt, ok_nxt, timeout_nxt;
    logic [15:0] err_nxt;
    logic [31:0] first_nxt;
    logic        acked, mismatch;

    wb_checker_pattern #(.SEED(SEED)) u_pattern (
        .adr     (adr_nxt),
        .pattern (pat_nxt)
    );

    assign wbm.wbm_sel_o = 4'hF;
    assign wbm.wbm_bte_o = BTE_LINEAR;

    // The data register always holds the pattern of the presented address while a
    // run is active, so the read compare can use it directly as the expected value.
    always_comb begin
        state_nxt   = state;
        beat_nxt    = beat_cnt;
        burst_nxt   = burst_cnt;
        wait_nxt    = wait_cnt;
        adr_nxt     = wbm.wbm_adr_o;
        cti_nxt     = wbm.wbm_cti_o;
        we_nxt      = wbm.wbm_we_o;
        cyc_nxt     = wbm.wbm_cyc_o;
        stb_nxt     = wbm.wbm_stb_o;
        timeout_nxt = timeout;
        err_nxt     = err_count;
        first_nxt   = first_err_adr;
        acked       = wbm.wbm_stb_o & wbm.wbm_ack_i;
        mismatch    = wbm.wbm_dat_i != wbm.wbm_dat_o;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt   = WR_BURST;
                    beat_nxt    = 4'd0;
                    burst_nxt   = 16'd0;
                    wait_nxt    = 32'd0;
                    adr_nxt     = BASE;
                    cti_nxt     = beat_cti(4'd0, LAST_BEAT);
                    we_nxt      = 1'b1;
                    cyc_nxt     = 1'b1;
                    stb_nxt     = 1'b1;
                    timeout_nxt = 1'b0;
                    err_nxt     = 16'd0;
                    first_nxt   = 32'd0;
                end
            end
            WR_BURST, RD_BURST: begin
                if (acked) begin
                    wait_nxt = 32'd0;
                    adr_nxt  = wbm.wbm_adr_o + 32'd4;
                    if (state == RD_BURST && mismatch) begin
                        if (err_count != 16'hFFFF)
                            err_nxt = err_count + 16'd1;
                        if (err_count == 16'd0)
                            first_nxt = wbm.wbm_adr_o;
                    end
                    if (beat_cnt == LAST_BEAT) begin
                        state_nxt = (state == WR_BURST) ? WR_GAP : RD_GAP;
                        beat_nxt  = 4'd0;
                        burst_nxt = burst_cnt + 16'd1;
                        cyc_nxt   = 1'b0;
                        stb_nxt   = 1'b0;
                    end else begin
                        beat_nxt = beat_cnt + 4'd1;
                        cti_nxt  = beat_cti(beat_cnt + 4'd1, LAST_BEAT);
                    end
                end else if (wait_cnt == TMO) begin
                    state_nxt   = DONE;
                    timeout_nxt = 1'b1;
                    we_nxt      = 1'b0;
                    cyc_nxt     = 1'b0;
                    stb_nxt     = 1'b0;
                end else begin
                    wait_nxt = wait_cnt + 32'd1;
                end
            end
            WR_GAP, RD_GAP: begin
                cti_nxt = beat_cti(4'd0, LAST_BEAT);
                cyc_nxt = 1'b1;
                stb_nxt = 1'b1;
                if (burst_cnt != BURSTS) begin
                    state_nxt = (state == WR_GAP) ? WR_BURST : RD_BURST;
                end else if (state == WR_GAP) begin
                    state_nxt = RD_BURST;
                    burst_nxt = 16'd0;
                    adr_nxt   = BASE;
                    we_nxt    = 1'b0;
                end else begin
                    state_nxt = DONE;
                    cyc_nxt   = 1'b0;
                    stb_nxt   = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt != IDLE) && (state_nxt != DONE);
        done_nxt = state_nxt == DONE;
        ok_nxt   = done_nxt && (err_nxt == 16'd0) && !timeout_nxt;
        dat_nxt  = busy_nxt ? pat_nxt : wbm.wbm_dat_o;
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state          <= IDLE;
            beat_cnt       <= 4'd0;
            burst_cnt      <= 16'd0;
            wait_cnt       <= 32'd0;
            wbm.wbm_adr_o  <= 32'd0;
            wbm.wbm_dat_o  <= 32'd0;
            wbm.wbm_cti_o  <= CTI_CLASSIC;
            wbm.wbm_we_o   <= 1'b0;
            wbm.wbm_cyc_o  <= 1'b0;
            wbm.wbm_stb_o  <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            ok             <= 1'b0;
            timeout        <= 1'b0;
            err_count      <= 16'd0;
            first_err_adr  <= 32'd0;
        end else begin
            state          <= state_nxt;
            beat_cnt       <= beat_nxt;
            burst_cnt      <= burst_nxt;
            wait_cnt       <= wait_nxt;
            wbm.wbm_adr_o  <= adr_nxt;
            wbm.wbm_dat_o  <= dat_nxt;
            wbm.wbm_cti_o  <= cti_nxt;
            wbm.wbm_we_o   <= we_nxt;
            wbm.wbm_cyc_o  <= cyc_nxt;
            wbm.wbm_stb_o  <= stb_nxt;
            busy           <= busy_nxt;
            done           <= done_nxt;
            ok             <= ok_nxt;
            timeout        <= timeout_nxt;
            err_count      <= err_nxt;
            first_err_adr  <= first_nxt;
        end
    end

endmodule

// File: tb/tb_wb_burst_checker.sv
// Directed bench for wb_burst_checker: four parameterisations, each with its own simple slave model.
module tb_wb_burst_checker;

    localparam logic [31:0] SEED = 32'hA5A5_0000;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [2:0]  cti;
        logic [3:0]  sel;
        logic [1:0]  bte;
    } beat_t;
    typedef beat_t beat_q_t[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start_a, start_b, start_c, start_d;
    logic corrupt_a;
    int   checks = 0;
    int   errors = 0;
    int   wr_acks_c;
    int   cyc_cycles_b, idle_busy_b;
    beat_q_t log_a, log_b, log_d;

    logic        busy_a, done_a, ok_a, tmo_a;
    logic        busy_b, done_b, ok_b, tmo_b;
    logic        busy_c, done_c, ok_c, tmo_c;
    logic        busy_d, done_d, ok_d, tmo_d;
    logic [15:0] err_a, err_b, err_c, err_d;
    logic [31:0] ferr_a, ferr_b, ferr_c, ferr_d;

    wb_burst_checker_if bus_a ();
    wb_burst_checker_if bus_b ();
    wb_burst_checker_if bus_c ();
    wb_burst_checker_if bus_d ();

    wb_burst_checker u_a (
        .wb_clk(clk), .wb_rst(rst), .start(start_a), .wbm(bus_a.master),
        .busy(busy_a), .done(done_a), .ok(ok_a), .timeout(tmo_a),
        .err_count(err_a), .first_err_adr(ferr_a)
    );

    wb_burst_checker #(.BURST_LEN(1), .NR_BURSTS(3)) u_b (
        .wb_clk(clk), .wb_rst(rst), .start(start_b), .wbm(bus_b.master),
        .busy(busy_b), .done(done_b), .ok(ok_b), .timeout(tmo_b),
        .err_count(err_b), .first_err_adr(ferr_b)
    );

    wb_burst_checker #(.TIMEOUT(15)) u_c (
        .wb_clk(clk), .wb_rst(rst), .start(start_c), .wbm(bus_c.master),
        .busy(busy_c), .done(done_c), .ok(ok_c), .timeout(tmo_c),
        .err_count(err_c), .first_err_adr(ferr_c)
    );

    wb_burst_checker #(.BASE_ADR(32'hFFFF_FFF8), .NR_BURSTS(1)) u_d (
        .wb_clk(clk), .wb_rst(rst), .start(start_d), .wbm(bus_d.master),
        .busy(busy_d), .done(done_d), .ok(ok_d), .timeout(tmo_d),
        .err_count(err_d), .first_err_adr(ferr_d)
    );

    function automatic logic [31:0] model_pat(input logic [31:0] adr);
        return {adr[31:2], 2'b00} ^ SEED;
    endfunction

    function automatic beat_t mk_beat(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                                      input logic [2:0] cti, input logic [3:0] sel, input logic [1:0] bte);
        beat_t b;
        b.we = we; b.adr = adr; b.dat = dat; b.cti = cti; b.sel = sel; b.bte = bte;
        return b;
    endfunction

    // Zero-wait slaves answering with the model pattern; slave C withholds the second write ack.
    assign bus_a.wbm_ack_i = bus_a.wbm_cyc_o & bus_a.wbm_stb_o;
    assign bus_a.wbm_dat_i = model_pat(bus_a.wbm_adr_o) ^ {31'd0, corrupt_a && (bus_a.wbm_adr_o == 32'h24)};
    assign bus_b.wbm_ack_i = bus_b.wbm_cyc_o & bus_b.wbm_stb_o;
    assign bus_b.wbm_dat_i = model_pat(bus_b.wbm_adr_o);
    assign bus_c.wbm_ack_i = bus_c.wbm_cyc_o & bus_c.wbm_stb_o & !(bus_c.wbm_we_o && wr_acks_c == 1);
    assign bus_c.wbm_dat_i = model_pat(bus_c.wbm_adr_o);
    assign bus_d.wbm_ack_i = bus_d.wbm_cyc_o & bus_d.wbm_stb_o;
    assign bus_d.wbm_dat_i = model_pat(bus_d.wbm_adr_o);

    always @(posedge clk) begin
        if (bus_a.wbm_cyc_o && bus_a.wbm_stb_o && bus_a.wbm_ack_i)
            log_a.push_back(mk_beat(bus_a.wbm_we_o, bus_a.wbm_adr_o, bus_a.wbm_dat_o,
                                    bus_a.wbm_cti_o, bus_a.wbm_sel_o, bus_a.wbm_bte_o));
        if (bus_b.wbm_cyc_o && bus_b.wbm_stb_o && bus_b.wbm_ack_i)
            log_b.push_back(mk_beat(bus_b.wbm_we_o, bus_b.wbm_adr_o, bus_b.wbm_dat_o,
                                    bus_b.wbm_cti_o, bus_b.wbm_sel_o, bus_b.wbm_bte_o));
        if (bus_d.wbm_cyc_o && bus_d.wbm_stb_o && bus_d.wbm_ack_i)
            log_d.push_back(mk_beat(bus_d.wbm_we_o, bus_d.wbm_adr_o, bus_d.wbm_dat_o,
                                    bus_d.wbm_cti_o, bus_d.wbm_sel_o, bus_d.wbm_bte_o));
    end

    always @(posedge clk) begin
        if (rst) begin
            wr_acks_c    <= 0;
            cyc_cycles_b <= 0;
            idle_busy_b  <= 0;
        end else begin
            if (bus_c.wbm_cyc_o && bus_c.wbm_stb_o && bus_c.wbm_ack_i && bus_c.wbm_we_o)
                wr_acks_c <= wr_acks_c + 1;
            if (bus_b.wbm_cyc_o)
                cyc_cycles_b <= cyc_cycles_b + 1;
            if (busy_b && !bus_b.wbm_cyc_o)
                idle_busy_b <= idle_busy_b + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int which);
        @(negedge clk);
        case (which)
            0: start_a = 1'b1;
            1: start_b = 1'b1;
            2: start_c = 1'b1;
            default: start_d = 1'b1;
        endcase
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
        start_d = 1'b0;
    endtask

    function automatic logic get_done(input int which);
        case (which)
            0: return done_a;
            1: return done_b;
            2: return done_c;
            default: return done_d;
        endcase
    endfunction

    task automatic waitDone(input int which, input int budget, input string tag);
        int n;
        n = 0;
        while (!get_done(which) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, {31'd0, get_done(which)}, 32'd1);
    endtask

    // Rebuilds the expected beat stream: all writes from base, then all reads from base.
    task automatic checkLog(input string tag, input beat_q_t log, input logic [31:0] base,
                            input int bl, input int nb);
        int          per, i;
        int          bad_we, bad_adr, bad_dat, bad_cti, bad_const;
        logic        exp_we;
        logic [31:0] exp_adr;
        logic [2:0]  exp_cti;
        per = bl * nb;
        bad_we = 0; bad_adr = 0; bad_dat = 0; bad_cti = 0; bad_const = 0;
        checkOutput({tag, "_beats"}, 32'(log.size()), 32'(2 * per));
        foreach (log[k]) begin
            i       = k % per;
            exp_we  = (k < per);
            exp_adr = base + 32'(4 * i);
            if (bl == 1)
                exp_cti = 3'b000;
            else
                exp_cti = ((i % bl) == bl - 1) ? 3'b111 : 3'b010;
            if (log[k].we !== exp_we) bad_we++;
            if (log[k].adr !== exp_adr) bad_adr++;
            if (exp_we && log[k].dat !== model_pat(exp_adr)) bad_dat++;
            if (log[k].cti !== exp_cti) bad_cti++;
            if (log[k].sel !== 4'hF || log[k].bte !== 2'b00) bad_const++;
        end
        checkOutput({tag, "_bad_we"}, 32'(bad_we), 32'd0);
        checkOutput({tag, "_bad_adr"}, 32'(bad_adr), 32'd0);
        checkOutput({tag, "_bad_wdat"}, 32'(bad_dat), 32'd0);
        checkOutput({tag, "_bad_cti"}, 32'(bad_cti), 32'd0);
        checkOutput({tag, "_bad_sel_bte"}, 32'(bad_const), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; start_d = 1'b0;
        corrupt_a = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        checkOutput("rst_adr", bus_a.wbm_adr_o, 32'd0);
        checkOutput("rst_dat", bus_a.wbm_dat_o, 32'd0);
        checkOutput("rst_sel", {28'd0, bus_a.wbm_sel_o}, 32'hF);
        checkOutput("rst_cti_bte", {27'd0, bus_a.wbm_cti_o, bus_a.wbm_bte_o}, 32'd0);
        checkOutput("rst_we_cyc_stb", {29'd0, bus_a.wbm_we_o, bus_a.wbm_cyc_o, bus_a.wbm_stb_o}, 32'd0);
        checkOutput("rst_flags", {28'd0, busy_a, done_a, ok_a, tmo_a}, 32'd0);
        checkOutput("rst_err", {16'd0, err_a}, 32'd0);
        checkOutput("rst_first_err", ferr_a, 32'd0);
        rst = 1'b0;

        // Default run against an ideal slave, with a stray start mid-run
        log_a.delete();
        applyStimulus(0);
        checkOutput("a_first_cyc_stb_we", {29'd0, bus_a.wbm_cyc_o, bus_a.wbm_stb_o, bus_a.wbm_we_o}, 32'd7);
        checkOutput("a_first_adr", bus_a.wbm_adr_o, 32'h0);
        checkOutput("a_first_dat", bus_a.wbm_dat_o, 32'hA5A5_0000);
        checkOutput("a_first_cti", {29'd0, bus_a.wbm_cti_o}, 32'd2);
        checkOutput("a_first_busy", {31'd0, busy_a}, 32'd1);
        repeat (10) @(negedge clk);
        applyStimulus(0);
        waitDone(0, 1000, "a_done_wait");
        checkOutput("a_ok", {31'd0, ok_a}, 32'd1);
        checkOutput("a_err", {16'd0, err_a}, 32'd0);
        checkOutput("a_first_err", ferr_a, 32'd0);
        checkOutput("a_busy_tmo", {30'd0, busy_a, tmo_a}, 32'd0);
        checkOutput("a_cyc_idle", {31'd0, bus_a.wbm_cyc_o}, 32'd0);
        checkLog("a", log_a, 32'h0, 4, 16);

        // Read data corrupted at 0x24
        corrupt_a = 1'b1;
        applyStimulus(0);
        waitDone(0, 1000, "corrupt_done_wait");
        checkOutput("corrupt_err", {16'd0, err_a}, 32'd1);
        checkOutput("corrupt_first_err", ferr_a, 32'h24);
        checkOutput("corrupt_ok", {31'd0, ok_a}, 32'd0);
        checkOutput("corrupt_tmo", {31'd0, tmo_a}, 32'd0);
        corrupt_a = 1'b0;

        // Single-beat bursts
        applyStimulus(1);
        waitDone(1, 200, "b_done_wait");
        checkOutput("b_ok", {31'd0, ok_b}, 32'd1);
        checkOutput("b_cyc_cycles", 32'(cyc_cycles_b), 32'd6);
        checkOutput("b_gap_cycles", 32'(idle_busy_b), 32'd6);
        checkLog("b", log_b, 32'h0, 1, 3);

        // Second write beat never acked
        applyStimulus(2);
        @(negedge clk);
        checkOutput("c_beat2_cyc", {31'd0, bus_c.wbm_cyc_o}, 32'd1);
        checkOutput("c_beat2_adr", bus_c.wbm_adr_o, 32'h4);
        repeat (15) @(negedge clk);
        checkOutput("c_pre_tmo_cyc_tmo", {30'd0, bus_c.wbm_cyc_o, tmo_c}, 32'd2);
        @(negedge clk);
        checkOutput("c_tmo_cyc_stb", {30'd0, bus_c.wbm_cyc_o, bus_c.wbm_stb_o}, 32'd0);
        checkOutput("c_tmo_flag", {31'd0, tmo_c}, 32'd1);
        checkOutput("c_tmo_done_ok", {30'd0, done_c, ok_c}, 32'd2);

        // Address wrap past the top of the address space
        applyStimulus(3);
        waitDone(3, 200, "d_done_wait");
        checkOutput("d_ok", {31'd0, ok_d}, 32'd1);
        checkLog("d", log_d, 32'hFFFF_FFF8, 4, 1);

        // Reset in the middle of a write burst, then a clean rerun
        applyStimulus(0);
        repeat (2) @(negedge clk);
        checkOutput("mid_cyc_before_rst", {31'd0, bus_a.wbm_cyc_o}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_cyc_stb", {30'd0, bus_a.wbm_cyc_o, bus_a.wbm_stb_o}, 32'd0);
        checkOutput("mid_rst_busy_done", {30'd0, busy_a, done_a}, 32'd0);
        rst = 1'b0;
        applyStimulus(0);
        waitDone(0, 1000, "rerun_done_wait");
        checkOutput("rerun_ok", {31'd0, ok_a}, 32'd1);
        checkOutput("rerun_err", {16'd0, err_a}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
